// File: rtl/rx_byte_framer_pkg.sv
// Shared rx framing constants: COM symbol default, lock-FSM state encodings, word/byte widths.
package rx_byte_framer_pkg;
   localparam int          BYTE_W         = 8;
   localparam int          WORD_W         = 32;
   localparam int          BYTES_PER_WORD = WORD_W / BYTE_W;
   localparam logic [7:0]  COM_BYTE_DEF   = 8'hBC;
   localparam int          CNT16_W        = 16;

   typedef enum logic {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } rx_state_t;
endpackage

// File: rtl/rx_byte_packer.sv
// Packs data bytes MSB-first into 32-bit words; word registered 1 cycle after 4th byte.
// No backpressure: accepts one byte per cycle, discard_i drops the partial word.
module rx_byte_packer
   import rx_byte_framer_pkg::*;
(
   input  logic              clk_4f,
   input  logic              reset_L,
   input  logic              byte_vld_i,
   input  logic [BYTE_W-1:0] byte_dat_i,
   input  logic              discard_i,
   output logic              partial_o,
   output logic [WORD_W-1:0] data_out_o,
   output logic              valid_out_o
);

   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [WORD_W-1:0] asm_q, asm_d;
   logic [WORD_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;

   always_comb begin
      byte_idx_d = byte_idx_q;
      asm_d      = asm_q;
      data_d     = data_q;
      valid_d    = 1'b0;
      if (discard_i) begin
         byte_idx_d = 2'd0;
      end else if (byte_vld_i) begin
         // first byte of the word lands in the top lane
         case (byte_idx_q)
            2'd0:    asm_d[31:24] = byte_dat_i;
            2'd1:    asm_d[23:16] = byte_dat_i;
            2'd2:    asm_d[15:8]  = byte_dat_i;
            default: asm_d[7:0]   = byte_dat_i;
         endcase
         if (byte_idx_q == 2'd3) begin
            data_d     = asm_d;
            valid_d    = 1'b1;
            byte_idx_d = 2'd0;
         end else begin
            byte_idx_d = byte_idx_q + 2'd1;
         end
      end
   end

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         byte_idx_q <= 2'd0;
         asm_q      <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         byte_idx_q <= byte_idx_d;
         asm_q      <= asm_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

   assign partial_o   = (byte_idx_q != 2'd0);
   assign data_out_o  = data_q;
   assign valid_out_o = valid_q;

endmodule

// File: rtl/rx_byte_framer.sv
// COM lock FSM + loss detection feeding rx_byte_packer; all outputs registered (1 cycle).
// No backpressure; RX_FRAMER_STATS_EN adds saturating word_cnt/err_cnt outputs.
module rx_byte_framer
   import rx_byte_framer_pkg::*;
#(
   parameter logic [7:0] COM_BYTE   = COM_BYTE_DEF,
   parameter int         LOCK_COUNT = 4,
   parameter int         LOSS_COUNT = 8
) (
   input  logic              clk_4f,
   input  logic              reset_L,
   input  logic [BYTE_W-1:0] sp_out,
   input  logic              valid_out_sp,
   output logic [WORD_W-1:0] data_out,
   output logic              valid_out,
   output logic              locked,
   output logic              frame_err
`ifdef RX_FRAMER_STATS_EN
   ,
   output logic [CNT16_W-1:0] word_cnt,
   output logic [CNT16_W-1:0] err_cnt
`endif
);

   localparam logic [3:0] LOCK_N = LOCK_COUNT[3:0];
   localparam logic [7:0] LOSS_N = LOSS_COUNT[7:0];

   rx_state_t  state_q, state_d;
   logic [3:0] com_cnt_q, com_cnt_d;
   logic [7:0] loss_cnt_q, loss_cnt_d;
   logic       frame_err_q, frame_err_d;
   logic       pack_vld, discard, partial;
   logic       is_com;
   logic [3:0] com_inc;
   logic [7:0] loss_inc;

   assign is_com   = (sp_out == COM_BYTE);
   assign com_inc  = (com_cnt_q == 4'hF) ? com_cnt_q : com_cnt_q + 4'd1;
   assign loss_inc = (loss_cnt_q == 8'hFF) ? loss_cnt_q : loss_cnt_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      com_cnt_d   = com_cnt_q;
      loss_cnt_d  = loss_cnt_q;
      frame_err_d = 1'b0;
      pack_vld    = 1'b0;
      discard     = 1'b0;
      case (state_q)
         ST_SEARCH: begin
            if (valid_out_sp) begin
               if (is_com) begin
                  com_cnt_d = com_inc;
                  if (com_inc >= LOCK_N) begin
                     state_d    = ST_LOCKED;
                     loss_cnt_d = 8'd0;
                     discard    = 1'b1;
                  end
               end else begin
                  com_cnt_d = 4'd0;
               end
            end
         end
         default: begin
            if (valid_out_sp) begin
               loss_cnt_d = 8'd0;
               if (!is_com) begin
                  pack_vld = 1'b1;
               end else if (partial) begin
                  discard     = 1'b1;
                  frame_err_d = 1'b1;
               end
            end else begin
               loss_cnt_d = loss_inc;
               if (loss_inc >= LOSS_N) begin
                  state_d     = ST_SEARCH;
                  com_cnt_d   = 4'd0;
                  discard     = 1'b1;
                  frame_err_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= ST_SEARCH;
         com_cnt_q   <= 4'd0;
         loss_cnt_q  <= 8'd0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         com_cnt_q   <= com_cnt_d;
         loss_cnt_q  <= loss_cnt_d;
         frame_err_q <= frame_err_d;
      end
   end

   rx_byte_packer u_packer (
      .clk_4f      (clk_4f),
      .reset_L     (reset_L),
      .byte_vld_i  (pack_vld),
      .byte_dat_i  (sp_out),
      .discard_i   (discard),
      .partial_o   (partial),
      .data_out_o  (data_out),
      .valid_out_o (valid_out)
   );

   assign locked    = (state_q == ST_LOCKED);
   assign frame_err = frame_err_q;

`ifdef RX_FRAMER_STATS_EN
   logic [CNT16_W-1:0] word_cnt_q, err_cnt_q;

   always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
         word_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         if (valid_out && word_cnt_q != 16'hFFFF) word_cnt_q <= word_cnt_q + 16'd1;
         if (frame_err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign word_cnt = word_cnt_q;
   assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_rx_byte_framer.sv
// Randomized + directed bench for rx_byte_framer against a queue-based framing model.
module tb_rx_byte_framer;
   localparam logic [7:0] COM = 8'hBC;
   localparam int LOCK_N = 4;
   localparam int LOSS_N = 8;

   logic        clk_4f = 1'b0;
   logic        reset_L = 1'b0;
   logic [7:0]  sp_out = 8'h00;
   logic        valid_out_sp = 1'b0;
   logic [31:0] data_out;
   logic        valid_out, locked, frame_err;
`ifdef RX_FRAMER_STATS_EN
   logic [15:0] word_cnt, err_cnt;
`endif

   always #5 clk_4f = ~clk_4f;

   rx_byte_framer #(.COM_BYTE(COM), .LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N)) dut (
      .clk_4f       (clk_4f),
      .reset_L      (reset_L),
      .sp_out       (sp_out),
      .valid_out_sp (valid_out_sp),
      .data_out     (data_out),
      .valid_out    (valid_out),
      .locked       (locked),
      .frame_err    (frame_err)
`ifdef RX_FRAMER_STATS_EN
      ,
      .word_cnt     (word_cnt),
      .err_cnt      (err_cnt)
`endif
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // reference model: a link is "locked" after LOCK_N back-to-back COMs;
   // data bytes collect in a queue and leave as a word once four are present
   bit        m_locked;
   int        m_com_run, m_idle_run;
   byte       m_part[$];
   bit [31:0] m_word;
   bit        m_vld, m_err;
   int        m_wc, m_ec;

   function automatic void model_reset();
      m_locked = 0; m_com_run = 0; m_idle_run = 0;
      m_part.delete(); m_word = 0; m_vld = 0; m_err = 0;
      m_wc = 0; m_ec = 0;
   endfunction

   function automatic void model_step(input bit v, input bit [7:0] d);
      m_vld = 0; m_err = 0;
      if (!m_locked) begin
         if (v) begin
            if (d == COM) begin
               m_com_run++;
               if (m_com_run >= LOCK_N) begin
                  m_locked = 1; m_idle_run = 0; m_part.delete();
               end
            end else m_com_run = 0;
         end
      end else if (v) begin
         m_idle_run = 0;
         if (d != COM) begin
            m_part.push_back(d);
            if (m_part.size() == 4) begin
               m_word = {m_part[0], m_part[1], m_part[2], m_part[3]};
               m_vld = 1; m_part.delete();
            end
         end else if (m_part.size() != 0) begin
            m_part.delete(); m_err = 1;
         end
      end else begin
         m_idle_run++;
         if (m_idle_run >= LOSS_N) begin
            m_locked = 0; m_com_run = 0; m_part.delete(); m_err = 1;
         end
      end
      if (m_vld && m_wc < 65535) m_wc++;
      if (m_err && m_ec < 65535) m_ec++;
   endfunction

   task automatic compare_all();
      chk("locked", {31'd0, locked}, {31'd0, m_locked});
      chk("valid_out", {31'd0, valid_out}, {31'd0, m_vld});
      chk("frame_err", {31'd0, frame_err}, {31'd0, m_err});
      chk("data_out", data_out, m_word);
      chk("vld_err_excl", {31'd0, valid_out & frame_err}, 32'd0);
`ifdef RX_FRAMER_STATS_EN
      chk("word_cnt", {16'd0, word_cnt}, m_wc[31:0]);
      chk("err_cnt", {16'd0, err_cnt}, m_ec[31:0]);
`endif
   endtask

   task automatic step(input bit v, input bit [7:0] d);
      @(negedge clk_4f);
      valid_out_sp = v;
      sp_out       = d;
      @(posedge clk_4f);
      model_step(v, d);
      #1;
      compare_all();
   endtask

   task automatic send_bytes(input bit [7:0] b[]);
      foreach (b[i]) step(1'b1, b[i]);
   endtask

   task automatic do_lock();
      for (int i = 0; i < LOCK_N; i++) step(1'b1, COM);
   endtask

   initial begin
      model_reset();
      #12;
      chk("rst_data_out", data_out, 32'd0);
      chk("rst_flags", {29'd0, valid_out, locked, frame_err}, 32'd0);
      reset_L = 1'b1;

      // lock acquisition, interrupted run first
      send_bytes('{COM, COM, COM, 8'h00});
      chk("no_early_lock", {31'd0, locked}, 32'd0);
      do_lock();
      chk("locked_after_run", {31'd0, locked}, 32'd1);

      // packing
      send_bytes('{8'h11, 8'h22, 8'h33, 8'h44});
      chk("pack_word", data_out, 32'h11223344);
      chk("pack_vld", {31'd0, valid_out}, 32'd1);
      step(1'b0, 8'h00);
      chk("pack_vld_pulse", {31'd0, valid_out}, 32'd0);
      chk("pack_hold", data_out, 32'h11223344);

      // idle interleave
      send_bytes('{COM, COM, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
      chk("idle_word", data_out, 32'hAABBCCDD);

      // mid-word COM
      send_bytes('{8'h01, 8'h02, COM});
      chk("midcom_err", {31'd0, frame_err}, 32'd1);
      send_bytes('{8'h05, 8'h06, 8'h07, 8'h08});
      chk("midcom_word", data_out, 32'h05060708);
      chk("midcom_locked", {31'd0, locked}, 32'd1);

      // loss of stream: 7 idle then valid keeps lock; 8 idle drops it
      for (int i = 0; i < LOSS_N - 1; i++) step(1'b0, 8'h00);
      step(1'b1, 8'h12);
      chk("loss7_locked", {31'd0, locked}, 32'd1);
      for (int i = 0; i < LOSS_N; i++) step(1'b0, 8'h00);
      chk("loss8_unlocked", {31'd0, locked}, 32'd0);
      chk("loss8_err", {31'd0, frame_err}, 32'd1);

      // async reset mid-word
      do_lock();
      send_bytes('{8'h5A, 8'hA5});
      #2 reset_L = 1'b0;
      #1;
      chk("arst_data_out", data_out, 32'd0);
      chk("arst_flags", {29'd0, valid_out, locked, frame_err}, 32'd0);
      model_reset();
      @(negedge clk_4f);
      reset_L = 1'b1;
      send_bytes('{8'h01, 8'h02, 8'h03, 8'h04, COM, COM, COM});
      chk("arst_no_word", {31'd0, valid_out}, 32'd0);
      chk("arst_relock_pending", {31'd0, locked}, 32'd0);
      step(1'b1, COM);
      chk("arst_relocked", {31'd0, locked}, 32'd1);

      // randomized traffic with occasional long idle bursts
      for (int i = 0; i < 3000; i++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 3) begin
            int len;
            len = int'($urandom_range(5, 12));
            for (int k = 0; k < len; k++) step(1'b0, 8'($urandom));
         end else if (r < 15) begin
            step(1'b0, 8'($urandom));
         end else if (r < 40) begin
            step(1'b1, COM);
         end else begin
            bit [7:0] b;
            b = 8'($urandom);
            step(1'b1, b);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
